hash_msg_feeder: RTL and testbench
==================================

HASH_MSG_FEEDER -- requirements
Module: hash_msg_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning message buffer size in bytes (power of two, 4..256).
REQ-002 SHALL have parameter CNT_W, default $clog2(DEPTH)+1, meaning occupancy counter width.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port wr_valid  input  1  host byte-write strobe.
REQ-006 SHALL have port wr_data  input  8  host message byte.
REQ-007 SHALL have port wr_ready  output  1  buffer accepts the byte this cycle.
REQ-008 SHALL have port start  input  1  single-cycle hash request.
REQ-009 SHALL have port msg_len  input  64  message length in bytes, sampled on start.
REQ-010 SHALL have port target  input  64  expected digest, sampled on start.
REQ-011 SHALL have ports busy, done, match, err  output  1 each  status.
REQ-012 SHALL have port digest  output  64  captured digest.
REQ-013 SHALL have ports M_valid  output  1, M  output  8, C_in  output  64  hash-core message side.
REQ-014 SHALL have ports hash_ready  input  1, digest_out  input  64  hash-core result side.

Function
REQ-015 SHALL buffer bytes in FIFO order; a write occurs when wr_valid && wr_ready; wr_ready = !full && state==IDLE.
REQ-016 SHALL implement FSM states IDLE, STREAM, WAIT, DONE.
REQ-017 IDLE: start with msg_len <= occupancy SHALL latch msg_len into C_in and target internally, go to STREAM (or WAIT if msg_len==0).
REQ-018 IDLE: start with msg_len > occupancy SHALL pulse err for one cycle, stay IDLE, and leave the buffer untouched.
REQ-019 STREAM: M_valid SHALL be 1 from the cycle after start; M SHALL present a new byte each cycle, with no gaps, for exactly msg_len cycles.
REQ-020 After the last byte, the block SHALL go to WAIT, where M holds the last byte (0 if msg_len==0) and M_valid stays 1.
REQ-021 WAIT: on the edge hash_ready is sampled 1, the block SHALL capture digest_out into digest, drop M_valid next cycle, and go to DONE.
REQ-022 hash_ready arriving during STREAM SHALL be ignored.
REQ-023 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-024 busy SHALL be 1 in STREAM and WAIT.
REQ-025 start while busy or in DONE SHALL be ignored, with no err.
REQ-026 Bytes beyond msg_len SHALL remain buffered for the next request.
REQ-027 C_in SHALL hold its latched value from STREAM entry until the next accepted start.
REQ-028 digest and match SHALL hold until the next DONE.
REQ-029 Simultaneous wr_valid and start in IDLE: the occupancy check SHALL use the pre-write count, and the write is still accepted.
REQ-030 Read and write pointers SHALL wrap modulo DEPTH, and occupancy SHALL never exceed DEPTH.

Reset
REQ-031 rst_n low SHALL force IDLE, empty the buffer, and clear wr_ready-gating state.
REQ-032 While rst_n is low, every output except wr_ready SHALL be 0; wr_ready SHALL be 1 after deassertion.
REQ-033 Reset mid-STREAM or mid-WAIT SHALL drop M_valid immediately, produce no done, and discard the message.

Configuration
REQ-034 With HASH_FEEDER_CMP_EN defined, match SHALL be registered at the DONE transition as (digest_out == latched target).
REQ-035 Without HASH_FEEDER_CMP_EN, match SHALL be constant 0, target SHALL be ignored, and no comparator or target register SHALL be synthesised.

Structure
REQ-036 Package hash_feeder_pkg SHALL hold the FSM state enum, DIGEST_W=64, LEN_W=64 and BYTE_W=8.
REQ-037 A single sub-module hash_feeder_fifo (byte FIFO: push, pop, full, empty, count) SHALL hold the buffer.
REQ-038 The FSM and output registers SHALL live in hash_msg_feeder.

Verification
REQ-039 Write "abc" (0x61,0x62,0x63), start msg_len=3 -> C_in=3, M=61,62,63 on three consecutive M_valid cycles, then M stays 63 until hash_ready.
REQ-040 Core returns digest_out=0x0123456789ABCDEF with target equal -> done pulse, digest=0x0123456789ABCDEF, match=1 (CMP_EN); repeat with target off by one bit -> match=0.
REQ-041 start msg_len=0 on an empty buffer -> WAIT immediately, M_valid=1, M=0, C_in=0, and done follows hash_ready.
REQ-042 Write 2 bytes, start msg_len=5 -> err pulses one cycle, busy stays 0, occupancy stays 2.
REQ-043 Fill DEPTH=64 bytes -> wr_ready=0 on the 65th write; stream 64 bytes -> pointers wrap and the byte order is preserved.
REQ-044 Assert rst_n=0 two cycles into STREAM -> M_valid=0 asynchronously, no done, buffer empty after release.

Source files
------------

// File: rtl/hash_feeder_pkg.sv
// Shared widths and FSM state encoding for the hash message feeder.
package hash_feeder_pkg;
   localparam int DIGEST_W = 64;
   localparam int LEN_W    = 64;
   localparam int BYTE_W   = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      WAIT   = 2'd2,
      DONE   = 2'd3
   } state_t;
endpackage

// File: rtl/hash_feeder_fifo.sv
// Byte FIFO holding the host message; dout shows the head combinationally, zero-latency pop.
// Push while full and pop while empty are dropped; the caller gates on full/empty.
module hash_feeder_fifo
   import hash_feeder_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [BYTE_W-1:0] din,
   input  logic              pop,
   output logic [BYTE_W-1:0] dout,
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  count
);
   localparam int AW = $clog2(DEPTH);

   logic [BYTE_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH for free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/hash_msg_feeder.sv
// Buffers host bytes and streams msg_len of them to a hash core, one per cycle, then captures the digest.
// wr_ready only in IDLE with room; optional digest/target compare under HASH_FEEDER_CMP_EN.
module hash_msg_feeder
   import hash_feeder_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_valid,
   input  logic [BYTE_W-1:0]   wr_data,
   output logic                wr_ready,
   input  logic                start,
   input  logic [LEN_W-1:0]    msg_len,
   input  logic [DIGEST_W-1:0] target,
   output logic                busy,
   output logic                done,
   output logic                match,
   output logic                err,
   output logic [DIGEST_W-1:0] digest,
   output logic                M_valid,
   output logic [BYTE_W-1:0]   M,
   output logic [LEN_W-1:0]    C_in,
   input  logic                hash_ready,
   input  logic [DIGEST_W-1:0] digest_out
);
   state_t            state;
   logic [CNT_W-1:0]  rem;
   logic [CNT_W-1:0]  occ;
   logic [BYTE_W-1:0] fifo_dout;
   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic              len_ok;
   logic              accept;

   assign wr_ready = !fifo_full && (state == IDLE);
   assign push     = wr_valid && wr_ready;

   // occ is the pre-write count, so a same-cycle write never satisfies the length check.
   always_comb begin
      len_ok = (msg_len <= {{(LEN_W-CNT_W){1'b0}}, occ});
      accept = (state == IDLE) && start && len_ok;
      pop    = !fifo_empty &&
               ((accept && (msg_len != '0)) || ((state == STREAM) && (rem != '0)));
   end

   hash_feeder_fifo #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (wr_data),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (occ)
   );

   // rem counts bytes still to load after the one currently on M.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         rem     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         M_valid <= 1'b0;
         M       <= '0;
         C_in    <= '0;
         digest  <= '0;
      end else begin
         err  <= 1'b0;
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (len_ok) begin
                     C_in    <= msg_len;
                     busy    <= 1'b1;
                     M_valid <= 1'b1;
                     if (msg_len == '0) begin
                        M     <= '0;
                        state <= WAIT;
                     end else begin
                        M     <= fifo_dout;
                        rem   <= msg_len[CNT_W-1:0] - CNT_W'(1);
                        state <= STREAM;
                     end
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            STREAM: begin
               if (rem != '0) begin
                  M   <= fifo_dout;
                  rem <= rem - CNT_W'(1);
               end else begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (hash_ready) begin
                  digest  <= digest_out;
                  M_valid <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef HASH_FEEDER_CMP_EN
   logic [DIGEST_W-1:0] tgt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tgt_q <= '0;
         match <= 1'b0;
      end else begin
         if (accept) tgt_q <= target;
         if ((state == WAIT) && hash_ready) match <= (digest_out == tgt_q);
      end
   end
`else
   logic unused_target;
   assign unused_target = ^target;
   assign match         = 1'b0;
`endif
endmodule

// File: tb/tb_hash_msg_feeder.sv
// Directed bench for hash_msg_feeder: a byte queue tracks buffer contents and is popped as M streams.
module tb_hash_msg_feeder;
   localparam int DEPTH = 64;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_valid;
   logic [7:0]  wr_data;
   logic        wr_ready;
   logic        start;
   logic [63:0] msg_len;
   logic [63:0] target;
   logic        busy, done, match, err;
   logic [63:0] digest;
   logic        M_valid;
   logic [7:0]  M;
   logic [63:0] C_in;
   logic        hash_ready;
   logic [63:0] digest_out;

   int          errors = 0;
   int          checks = 0;
   logic [7:0]  model_q [$];
   logic [63:0] prev_digest = '0;
   logic        prev_match  = 1'b0;

   hash_msg_feeder #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_valid   (wr_valid),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .start      (start),
      .msg_len    (msg_len),
      .target     (target),
      .busy       (busy),
      .done       (done),
      .match      (match),
      .err        (err),
      .digest     (digest),
      .M_valid    (M_valid),
      .M          (M),
      .C_in       (C_in),
      .hash_ready (hash_ready),
      .digest_out (digest_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called right after a negedge; returns right after the next one.
   task automatic write_byte(input logic [7:0] b);
      logic exp_rdy;
      exp_rdy = (model_q.size() < DEPTH);
      chk("wr_ready", {63'd0, wr_ready}, {63'd0, exp_rdy});
      wr_valid = 1'b1;
      wr_data  = b;
      if (exp_rdy) model_q.push_back(b);
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   task automatic run_hash(input logic [63:0] len, input logic [63:0] tgt,
                           input logic [63:0] dig, input logic exp_err);
      logic [7:0] last_b;
      logic       exp_match;
      chk("digest_hold", digest, prev_digest);
      chk("match_hold", {63'd0, match}, {63'd0, prev_match});
      start   = 1'b1;
      msg_len = len;
      target  = tgt;
      @(negedge clk);
      start = 1'b0;
      if (exp_err) begin
         chk("err_pulse", {63'd0, err}, 64'd1);
         chk("err_busy", {63'd0, busy}, 64'd0);
         chk("err_mvalid", {63'd0, M_valid}, 64'd0);
         @(negedge clk);
         chk("err_clear", {63'd0, err}, 64'd0);
         return;
      end
      chk("c_in", C_in, len);
      chk("stream_wr_ready", {63'd0, wr_ready}, 64'd0);
      last_b = 8'h00;
      for (int i = 0; i < int'(len); i++) begin
         last_b = model_q.pop_front();
         chk("m_valid", {63'd0, M_valid}, 64'd1);
         chk("m_byte", {56'd0, M}, {56'd0, last_b});
         chk("busy_stream", {63'd0, busy}, 64'd1);
         hash_ready = (i == 0);
         digest_out = 64'hDEAD_BEEF_0000_0000;
         @(negedge clk);
      end
      hash_ready = 1'b0;
      for (int w = 0; w < 3; w++) begin
         chk("wait_mvalid", {63'd0, M_valid}, 64'd1);
         chk("wait_m", {56'd0, M}, {56'd0, last_b});
         chk("wait_done", {63'd0, done}, 64'd0);
         chk("wait_busy", {63'd0, busy}, 64'd1);
         if (w == 2) chk("busy_start_no_err", {63'd0, err}, 64'd0);
         start   = (w == 1);
         msg_len = 64'd100;
         @(negedge clk);
      end
      start      = 1'b0;
      hash_ready = 1'b1;
      digest_out = dig;
      @(negedge clk);
      hash_ready = 1'b0;
`ifdef HASH_FEEDER_CMP_EN
      exp_match = (dig == tgt);
`else
      exp_match = 1'b0;
`endif
      chk("done_pulse", {63'd0, done}, 64'd1);
      chk("done_digest", digest, dig);
      chk("done_match", {63'd0, match}, {63'd0, exp_match});
      chk("done_mvalid", {63'd0, M_valid}, 64'd0);
      chk("done_busy", {63'd0, busy}, 64'd0);
      chk("c_in_hold", C_in, len);
      start   = 1'b1;
      msg_len = 64'd0;
      @(negedge clk);
      start      = 1'b0;
      digest_out = ~dig;
      chk("done_once", {63'd0, done}, 64'd0);
      chk("done_start_ignored", {63'd0, busy}, 64'd0);
      chk("done_start_no_err", {63'd0, err}, 64'd0);
      prev_digest = dig;
      prev_match  = exp_match;
   endtask

   initial begin
      rst_n      = 1'b0;
      wr_valid   = 1'b0;
      wr_data    = '0;
      start      = 1'b0;
      msg_len    = '0;
      target     = '0;
      hash_ready = 1'b0;
      digest_out = '0;
      #3;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_match", {63'd0, match}, 64'd0);
      chk("rst_err", {63'd0, err}, 64'd0);
      chk("rst_mvalid", {63'd0, M_valid}, 64'd0);
      chk("rst_m", {56'd0, M}, 64'd0);
      chk("rst_c_in", C_in, 64'd0);
      chk("rst_digest", digest, 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_wr_ready", {63'd0, wr_ready}, 64'd1);

      // "abc" with matching target, then a one-bit-off target
      write_byte(8'h61);
      write_byte(8'h62);
      write_byte(8'h63);
      run_hash(64'd3, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0);
      write_byte(8'h61);
      write_byte(8'h62);
      write_byte(8'h63);
      run_hash(64'd3, 64'h0123_4567_89AB_CDEE, 64'h0123_4567_89AB_CDEF, 1'b0);

      // zero-length message on an empty buffer
      run_hash(64'd0, 64'h0, 64'h1111_2222_3333_4444, 1'b0);

      // over-long request, then same-cycle write and start checked against pre-write count
      write_byte(8'hA1);
      write_byte(8'hA2);
      run_hash(64'd5, 64'h0, 64'h0, 1'b1);
      wr_valid = 1'b1;
      wr_data  = 8'hA3;
      start    = 1'b1;
      msg_len  = 64'd3;
      chk("concurrent_wr_ready", {63'd0, wr_ready}, 64'd1);
      model_q.push_back(8'hA3);
      @(negedge clk);
      wr_valid = 1'b0;
      start    = 1'b0;
      chk("concurrent_err", {63'd0, err}, 64'd1);
      chk("concurrent_busy", {63'd0, busy}, 64'd0);
      @(negedge clk);
      run_hash(64'd1, 64'h0, 64'h5555_0000_5555_0000, 1'b0);
      run_hash(64'd2, 64'h5555_0000_6666_0000, 64'h5555_0000_6666_0000, 1'b0);

      // fill to DEPTH from a non-zero pointer; the extra write must be refused
      for (int k = 0; k < DEPTH + 1; k++) write_byte(8'($urandom_range(0, 255)));
      chk("model_full", 64'(model_q.size()), 64'(DEPTH));
      run_hash(64'(DEPTH), 64'h0, 64'hFEED_FACE_CAFE_BABE, 1'b0);

      // asynchronous reset two cycles into STREAM
      for (int k = 0; k < 5; k++) write_byte(8'h70 + 8'(k));
      start   = 1'b1;
      msg_len = 64'd5;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_mvalid", {63'd0, M_valid}, 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_mvalid", {63'd0, M_valid}, 64'd0);
      chk("async_rst_busy", {63'd0, busy}, 64'd0);
      @(negedge clk);
      chk("rst_no_done", {63'd0, done}, 64'd0);
      rst_n = 1'b1;
      model_q.delete();
      prev_digest = '0;
      prev_match  = 1'b0;
      @(negedge clk);
      chk("rst_release_done", {63'd0, done}, 64'd0);
      chk("rst_release_wr_ready", {63'd0, wr_ready}, 64'd1);
      run_hash(64'd1, 64'h0, 64'h0, 1'b1);
      write_byte(8'hC7);
      run_hash(64'd1, 64'h0, 64'h0BAD_F00D_0BAD_F00D, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
